// File: rtl/ir_nec_tx.sv
// ir_nec_tx: NEC infrared transmitter (leader, 32 LSB-first data bits, stop burst, gap to a fixed frame length).
// Define IR_TX_REPEAT_EN to emit NEC repeat codes while repeat_req is held at the end of each gap.
module ir_nec_tx #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int FRAME_UNITS  = 192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    input  logic       repeat_req,
    output logic       busy,
    output logic       done,
    output logic       ir_env,
    output logic       ir_tx
);
    localparam int UW = $clog2(UNIT_CYCLES + 1);
    localparam int CW = $clog2(CARRIER_HALF + 1);

    typedef enum logic [3:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
`ifdef IR_TX_REPEAT_EN
        , REP_MARK, REP_SPACE, REP_STOP, REP_GAP
`endif
    } state_t;

    state_t         state, nxt;
    logic [31:0]    data;
    logic [4:0]     bit_idx, seg_cnt, seg_len;
    logic [UW-1:0]  unit_cnt;
    logic [CW-1:0]  car_cnt;
    logic [7:0]     frame_cnt;
    logic           mark, nxt_mark, unit_tick, seg_end, frame_end, accept, rep_start, car_wrap;

    function automatic logic is_mark(state_t s);
`ifdef IR_TX_REPEAT_EN
        return s == LEAD_MARK || s == BIT_MARK || s == STOP_MARK || s == REP_MARK || s == REP_STOP;
`else
        return s == LEAD_MARK || s == BIT_MARK || s == STOP_MARK;
`endif
    endfunction

    assign unit_tick = unit_cnt == UW'(UNIT_CYCLES - 1);
    assign seg_end   = unit_tick && seg_cnt == seg_len - 5'd1;
    assign frame_end = unit_tick && frame_cnt == 8'(FRAME_UNITS - 1);
    assign accept    = state == IDLE && start && !done;
    assign mark      = is_mark(state);
    assign nxt_mark  = is_mark(nxt);
    assign car_wrap  = car_cnt == CW'(CARRIER_HALF - 1);
    assign busy      = state != IDLE;
    assign ir_env    = !mark;

`ifdef IR_TX_REPEAT_EN
    assign rep_start = nxt == REP_MARK && state != REP_MARK;
`else
    logic unused_repeat;
    assign unused_repeat = repeat_req;
    assign rep_start = 1'b0;
`endif

    always_comb begin
        seg_len = 5'd1;
        case (state)
            LEAD_MARK:  seg_len = 5'd16;
            LEAD_SPACE: seg_len = 5'd8;
            BIT_SPACE:  seg_len = data[bit_idx] ? 5'd3 : 5'd1;
`ifdef IR_TX_REPEAT_EN
            REP_MARK:   seg_len = 5'd16;
            REP_SPACE:  seg_len = 5'd4;
`endif
            default:    seg_len = 5'd1;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = accept ? LEAD_MARK : IDLE;
            LEAD_MARK:  if (seg_end) nxt = LEAD_SPACE;
            LEAD_SPACE: if (seg_end) nxt = BIT_MARK;
            BIT_MARK:   if (seg_end) nxt = BIT_SPACE;
            BIT_SPACE:  if (seg_end) nxt = bit_idx == 5'd31 ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (seg_end) nxt = GAP;
`ifdef IR_TX_REPEAT_EN
            GAP, REP_GAP: if (frame_end) nxt = repeat_req ? REP_MARK : IDLE;
            REP_MARK:   if (seg_end) nxt = REP_SPACE;
            REP_SPACE:  if (seg_end) nxt = REP_STOP;
            REP_STOP:   if (seg_end) nxt = REP_GAP;
`else
            GAP:        if (frame_end) nxt = IDLE;
`endif
            default:    nxt = IDLE;
        endcase
    end

    // Unit, segment and frame counters only advance while busy, so accept always starts them at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            data      <= '0;
            bit_idx   <= '0;
            seg_cnt   <= '0;
            unit_cnt  <= '0;
            frame_cnt <= '0;
            car_cnt   <= '0;
            ir_tx     <= 1'b0;
        end else begin
            state     <= nxt;
            done      <= busy && nxt == IDLE;
            if (accept) data <= {~cmd, cmd, ~addr, addr};
            unit_cnt  <= (!busy || unit_tick) ? '0 : unit_cnt + 1'b1;
            seg_cnt   <= (!busy || nxt != state) ? '0 : unit_tick ? seg_cnt + 5'd1 : seg_cnt;
            bit_idx   <= !busy ? '0 : (state == BIT_SPACE && seg_end && bit_idx != 5'd31) ? bit_idx + 5'd1 : bit_idx;
            frame_cnt <= (!busy || rep_start) ? '0 : (unit_tick && frame_cnt != 8'(FRAME_UNITS)) ? frame_cnt + 8'd1 : frame_cnt;
            if (nxt_mark && !mark) begin
                car_cnt <= '0;
                ir_tx   <= 1'b1;
            end else if (nxt_mark) begin
                car_cnt <= car_wrap ? '0 : car_cnt + 1'b1;
                if (car_wrap) ir_tx <= !ir_tx;
            end else begin
                car_cnt <= '0;
                ir_tx   <= 1'b0;
            end
        end
    end
endmodule
